// File: rtl/entropy_word_gate.sv
// Qualifies a raw TRNG bitstream after a clean startup window, packs it into words,
// drops words touched by health-test failures and buffers clean words in a small FIFO.
module entropy_word_gate #(
  parameter int WORD_W       = 8,
  parameter int STARTUP_BITS = 1024,
  parameter int ALARM_LIMIT  = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              rct_failure,
  input  logic              clear_alarm,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              startup_done,
  output logic              alarm,
  output logic [7:0]        fail_count,
  output logic              overflow
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [15:0]   SU_TARGET = 16'(STARTUP_BITS);
  localparam logic [7:0]    ALARM_AT  = 8'(ALARM_LIMIT);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_RUN,
    ST_ALARM
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       su_cnt_q, su_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              taint_q, taint_d;
  logic              fail_prev_q;
  logic [7:0]        fail_cnt_q, fail_cnt_d;
  logic              ovf_q, ovf_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic              fifo_empty, fifo_full, pop, push, push_ok, fail_event, trip;
  logic [WORD_W-1:0] word_new;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign word_valid = ~fifo_empty;
  assign word_out   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign pop        = word_valid & word_ready;
  assign fail_event = rct_failure & ~fail_prev_q;
  assign word_new   = {shift_q[WORD_W-2:0], bit_in};

  assign startup_done = (state_q == ST_RUN);
  assign alarm        = (state_q == ST_ALARM);
  assign fail_count   = fail_cnt_q;
  assign overflow     = ovf_q;

  always_comb begin
    state_d    = state_q;
    su_cnt_d   = su_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    taint_d    = taint_q;
    fail_cnt_d = fail_cnt_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    push_ok    = 1'b0;
    trip       = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (state_q != ST_ALARM && fail_event && fail_cnt_q != 8'hFF) begin
      fail_cnt_d = fail_cnt_q + 8'd1;
      trip       = (fail_cnt_d == ALARM_AT);
    end

    case (state_q)
      ST_STARTUP: begin
        if (rct_failure) begin
          su_cnt_d = '0;
        end else if (bit_valid) begin
          su_cnt_d = su_cnt_q + 16'd1;
          if (su_cnt_d == SU_TARGET) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        taint_d = taint_q | rct_failure;
        if (bit_valid) begin
          shift_d = word_new;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            push      = ~(taint_q | rct_failure);
            // a failure on the final bit also taints the following word
            taint_d   = rct_failure;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_ALARM: begin
        if (clear_alarm) begin
          state_d    = ST_STARTUP;
          fail_cnt_d = '0;
          ovf_d      = 1'b0;
          su_cnt_d   = '0;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    push_ok = push & (~fifo_full | pop);
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    // alarm entry wins over everything: flush the FIFO and drop the partial word
    if (trip) begin
      state_d   = ST_ALARM;
      shift_d   = '0;
      bit_cnt_d = '0;
      taint_d   = 1'b0;
      push_ok   = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STARTUP;
      su_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      taint_q     <= 1'b0;
      fail_prev_q <= 1'b0;
      fail_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      su_cnt_q    <= su_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      taint_q     <= taint_d;
      fail_prev_q <= rct_failure;
      fail_cnt_q  <= fail_cnt_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= word_new;
  end

endmodule

// File: tb/tb_entropy_word_gate.sv
// Scoreboard bench for entropy_word_gate: a queue-based reference model predicts
// accepted words; a negedge monitor pops and compares whatever the FIFO presents.
module tb_entropy_word_gate;
  localparam int W  = 8;
  localparam int SB = 16;
  localparam int AL = 4;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst, bit_in, bit_valid, rct_failure, clear_alarm, word_ready;
  logic [W-1:0] word_out;
  logic         word_valid, startup_done, alarm, overflow;
  logic [7:0]   fail_count;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  entropy_word_gate #(
    .WORD_W(W), .STARTUP_BITS(SB), .ALARM_LIMIT(AL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .rct_failure(rct_failure), .clear_alarm(clear_alarm),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .startup_done(startup_done), .alarm(alarm), .fail_count(fail_count),
    .overflow(overflow)
  );

  // reference model state
  typedef enum {M_STARTUP, M_RUN, M_ALARM} mmode_t;
  mmode_t       m_mode;
  int           m_su, m_fails, m_occ;
  bit           m_prev, m_taint, m_ovf;
  bit           m_bits[$];
  logic [W-1:0] exp_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_mode = M_STARTUP; m_su = 0; m_fails = 0; m_occ = 0;
    m_prev = 0; m_taint = 0; m_ovf = 0;
    m_bits.delete();
    exp_q.delete();
  endtask

  task automatic model_step();
    bit ev, pop, trip;
    logic [W-1:0] w;
    ev     = rct_failure && !m_prev;
    m_prev = rct_failure;
    pop    = word_ready && (m_occ > 0);
    trip   = 0;
    if (m_mode == M_ALARM) begin
      if (clear_alarm) begin
        m_mode = M_STARTUP; m_fails = 0; m_ovf = 0; m_su = 0;
      end
    end else begin
      if (ev && m_fails < 255) begin
        m_fails++;
        trip = (m_fails == AL);
      end
      if (trip) begin
        m_mode = M_ALARM; m_bits.delete(); m_taint = 0; exp_q.delete(); m_occ = 0;
      end else begin
        if (pop) m_occ--;
        if (m_mode == M_STARTUP) begin
          if (rct_failure) m_su = 0;
          else if (bit_valid) begin
            m_su++;
            if (m_su == SB) m_mode = M_RUN;
          end
        end else begin
          if (rct_failure) m_taint = 1;
          if (bit_valid) begin
            m_bits.push_back(bit_in);
            if (m_bits.size() == W) begin
              w = '0;
              foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
              if (!m_taint) begin
                if (m_occ < FD) begin
                  exp_q.push_back(w);
                  m_occ++;
                end else m_ovf = 1;
              end
              m_bits.delete();
              m_taint = rct_failure;
            end
          end
        end
      end
    end
  endtask

  task automatic status_check();
    check("startup_done", startup_done, m_mode == M_RUN);
    check("alarm", alarm, m_mode == M_ALARM);
    check("fail_count", fail_count, m_fails);
    check("overflow", overflow, m_ovf);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("word_valid", word_valid, exp_q.size() > 0);
      if (word_valid && exp_q.size() > 0) begin
        check("word_out", word_out, exp_q[0]);
        if (word_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(bit bv, bit b, bit f, bit clr, bit rdy);
    bit_valid = bv; bit_in = b; rct_failure = f; clear_alarm = clr; word_ready = rdy;
    @(negedge clk); #1;
    model_step();
    @(posedge clk); #1;
    status_check();
  endtask

  task automatic do_reset();
    rst = 1; bit_valid = 0; bit_in = 0; rct_failure = 0; clear_alarm = 0; word_ready = 0;
    @(negedge clk); #1;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    status_check();
    check("reset_word_out", word_out, 0);
    check("reset_word_valid", word_valid, 0);
  endtask

  task automatic send_byte(logic [7:0] v, int taint_at, bit rdy);
    for (int i = 0; i < W; i++) cyc(1, v[W-1-i], i == taint_at, 0, rdy);
  endtask

  task automatic pulse(bit rdy);
    cyc(0, 0, 1, 0, rdy);
    cyc(0, 0, 0, 0, rdy);
  endtask

  task automatic clean_startup(bit rdy);
    for (int i = 0; i < SB; i++) cyc(1, 1'($urandom), 0, 0, rdy);
  endtask

  initial begin
    rst = 0; bit_valid = 0; bit_in = 0; rct_failure = 0; clear_alarm = 0; word_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1;

    // startup with a restart after bit 10
    for (int i = 0; i < 10; i++) cyc(1, 1'($urandom), 0, 0, 1);
    pulse(1);
    check("still_startup", startup_done, 0);
    for (int i = 0; i < SB - 1; i++) cyc(1, 1'($urandom), 0, 0, 1);
    check("before_last_startup_bit", startup_done, 0);
    cyc(1, 1'($urandom), 0, 0, 1);
    check("startup_done_after_restart", startup_done, 1);
    check("fail_after_restart", fail_count, 1);
    check("no_words_in_startup", word_valid, 0);

    // packing
    send_byte(8'hB2, -1, 1);
    check("pack_valid", word_valid, 1);
    check("pack_word", word_out, 8'hB2);
    cyc(0, 0, 0, 0, 1);
    check("pack_one_cycle", word_valid, 0);

    // taint on the 4th bit, then a clean 5A
    send_byte(8'($urandom), 3, 1);
    check("tainted_dropped", word_valid, 0);
    send_byte(8'h5A, -1, 1);
    check("after_taint_word", word_out, 8'h5A);
    check("after_taint_fails", fail_count, 2);
    cyc(0, 0, 0, 0, 1);

    // backpressure: 5 words into a 4-deep FIFO
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), -1, 0);
    check("bp_overflow", overflow, 1);
    repeat (6) cyc(0, 0, 0, 0, 1);
    check("bp_drained", word_valid, 0);

    // alarm with two words buffered
    do_reset();
    clean_startup(0);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), -1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("two_buffered", word_valid, 1);
    for (int k = 0; k < AL - 1; k++) pulse(0);
    check("pre_alarm", alarm, 0);
    cyc(0, 0, 1, 0, 0);
    check("alarm_set", alarm, 1);
    check("alarm_flush", word_valid, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1'($urandom), 0, 0, 1);
    check("alarm_ignores_bits", word_valid, 0);
    check("alarm_fail_count", fail_count, AL);
    cyc(0, 0, 0, 1, 1);
    check("clear_alarm_off", alarm, 0);
    check("clear_fail_zero", fail_count, 0);
    check("clear_ovf_zero", overflow, 0);

    // rst mid-RUN with words buffered
    clean_startup(0);
    send_byte(8'($urandom), -1, 0);
    send_byte(8'($urandom), -1, 0);
    cyc(0, 0, 1, 0, 0);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(1499) == 0) do_reset();
      else cyc(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(49) == 0),
               ($urandom_range(99) == 0), ($urandom_range(2) != 0));
    end
    repeat (8) cyc(0, 0, 0, 0, 1);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
